meteor_mover: RTL and testbench
===============================

// Module: meteor_mover
// PURPOSE
//  Consumer of the per-frame strobe and speed value produced by the meteor speed block.
//  Advances one meteor down the 640x480 playfield by a speed-dependent step once per frame.
//  Respawns the meteor at a pseudo-random X each time it leaves the bottom edge.
//  Counts dodged meteors, and freezes the meteor on a collision report from the player logic.
//  Outputs feed the pixel renderer and the collision checker.
// PARAMETERS
//  SCREEN_W  640      playfield width in pixels
//  SCREEN_H  480      playfield height; meteor respawns when y >= SCREEN_H
//  MET_SIZE  16       meteor width; spawn X range is 0..SCREEN_W-MET_SIZE-1
//  X_SEED    16'hACE1 LFSR reset value; must be nonzero
// PORTS
//  clk         in   1   system clock, also the pixel clock
//  rst         in   1   synchronous, active-high reset
//  frame       in   1   frame strobe; may stay high for several consecutive cycles
//  speed       in   16  pixels per frame to move
//  start       in   1   begin the game, or restart after a hit
//  pause       in   1   suppresses motion while high
//  collide     in   1   player/meteor overlap reported this cycle
//  met_x       out  16  meteor left X
//  met_y       out  16  meteor top Y
//  met_active  out  1   meteor is visible (states RESPAWN, FALL, HIT)
//  hit         out  1   high while in state HIT
//  dodged      out  1   one-cycle pulse when the meteor exits the bottom edge
//  dodge_count out  16  number of meteors dodged, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset values: state=IDLE, met_x=0, met_y=0, met_active=0, hit=0, dodged=0,
//   dodge_count=0, lfsr=X_SEED, frame_q=0.
//  Frame tick:
//   - frame_q <= frame; tick = frame & ~frame_q.
//   - A high run of frame of any length produces exactly one tick.
//  LFSR:
//   - 16-bit Galois, right shift, XOR mask 16'hB400 applied when bit0=1.
//   - Advances every cycle in every state except under rst.
//  State IDLE:
//   - met_active=0.
//   - start -> RESPAWN. Otherwise stay.
//  State RESPAWN (exactly 1 cycle):
//   - r = lfsr[9:0]; R = SCREEN_W-MET_SIZE.
//   - met_x <= (r >= R) ? r-R : r. For 10-bit r this is always < R.
//   - met_y <= 0; next state FALL.
//  State FALL:
//   - Priority 1: collide -> HIT. Position is held; a tick in the same cycle is ignored.
//   - Priority 2: tick & ~pause: ny = {1'b0,met_y} + step, computed at 17 bits.
//       ny >= SCREEN_H: dodged pulse, dodge_count += 1 (saturating), next state RESPAWN;
//         met_y is not written with ny.
//       otherwise: met_y <= ny[15:0].
//   - step = speed. speed=0 means the meteor stays put.
//  State HIT:
//   - hit=1; met_x and met_y frozen.
//   - start -> RESPAWN and dodge_count <= 0.
//  Global rules:
//   - start is ignored in FALL and RESPAWN. collide is ignored outside FALL.
//   - dodged is high only in the cycle following the exiting tick.
//   - Latency: met_y updates on the clock edge after tick is detected.
//   - rst mid-game forces the reset values on the next edge, regardless of other inputs.
// CONFIGURATION
//  METEOR_ACCEL_EN defined:
//   - step = speed + {4'b0, dodge_count[15:4]}, saturating at 16'hFFFF.
//   - The meteor speeds up by 1 px/frame for every 16 dodges.
//  METEOR_ACCEL_EN undefined:
//   - step = speed exactly; dodge_count does not affect motion.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs at reset values; lfsr=16'hACE1.
//  2. start pulse, then frame high 2 cycles with speed=4 -> one RESPAWN, met_y 0->4 (not 8),
//     met_x < 624.
//  3. speed=100; after 4 ticks met_y=400 -> 5th tick: dodged=1 for 1 cycle, dodge_count=1,
//     met_y=0 after RESPAWN.
//  4. collide and tick in the same cycle at met_y=40 -> hit=1, met_y stays 40;
//     further ticks do not move it; start -> met_y=0, dodge_count=0.
//  5. pause=1 across 3 ticks with speed=8 -> met_y unchanged; pause=0, 1 tick -> +8.
//  6. METEOR_ACCEL_EN with dodge_count=32, speed=2 -> step=4 per tick.
//     Without the macro -> step=2. Also check rst asserted mid-FALL -> IDLE next cycle.

Source files
------------

// File: rtl/meteor_mover.sv
// meteor_mover: drops one meteor down the 640x480 playfield once per frame, respawning at a pseudo-random X,
// counting dodges and freezing on collision. Define METEOR_ACCEL_EN to add 1 px/frame for every 16 dodges.
module meteor_mover #(
   parameter int          SCREEN_W = 640,
   parameter int          SCREEN_H = 480,
   parameter int          MET_SIZE = 16,
   parameter logic [15:0] X_SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame,
   input  logic [15:0] speed,
   input  logic        start,
   input  logic        pause,
   input  logic        collide,
   output logic [15:0] met_x,
   output logic [15:0] met_y,
   output logic        met_active,
   output logic        hit,
   output logic        dodged,
   output logic [15:0] dodge_count
);
   typedef enum logic [1:0] {S_IDLE, S_RESPAWN, S_FALL, S_HIT} state_t;
   localparam logic [9:0] X_RANGE = 10'(SCREEN_W - MET_SIZE);
   state_t      r_state, w_next;
   logic        r_frame_q;
   logic [15:0] r_lfsr;
   logic        w_tick, w_move, w_exit;
   logic [15:0] w_step;
   logic [16:0] w_ny;
   logic [9:0]  w_spawn_x;
   assign w_tick    = frame & ~r_frame_q;
   assign w_spawn_x = (r_lfsr[9:0] >= X_RANGE) ? r_lfsr[9:0] - X_RANGE : r_lfsr[9:0];
`ifdef METEOR_ACCEL_EN
   logic [16:0] w_accel;
   assign w_accel = {1'b0, speed} + {5'b0, dodge_count[15:4]};
   assign w_step  = w_accel[16] ? 16'hFFFF : w_accel[15:0];
`else
   assign w_step = speed;
`endif
   assign w_ny   = {1'b0, met_y} + {1'b0, w_step};
   assign w_move = (r_state == S_FALL) & ~collide & w_tick & ~pause;
   assign w_exit = w_move & (w_ny >= 17'(SCREEN_H));
   // next state plus the state-decoded visibility and hit flags
   always_comb begin
      w_next     = r_state;
      met_active = r_state != S_IDLE;
      hit        = r_state == S_HIT;
      case (r_state)
         S_IDLE:    w_next = start ? S_RESPAWN : S_IDLE;
         S_RESPAWN: w_next = S_FALL;
         S_FALL:    w_next = collide ? S_HIT : (w_exit ? S_RESPAWN : S_FALL);
         S_HIT:     w_next = start ? S_RESPAWN : S_HIT;
         default:   w_next = S_IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end
   // frame edge detect, free-running LFSR, meteor position and dodge bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_q   <= 1'b0;
         r_lfsr      <= X_SEED;
         met_x       <= '0;
         met_y       <= '0;
         dodged      <= 1'b0;
         dodge_count <= '0;
      end else begin
         r_frame_q <= frame;
         r_lfsr    <= r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ 16'hB400) : {1'b0, r_lfsr[15:1]};
         dodged    <= w_exit;
         if (r_state == S_RESPAWN) begin
            met_x <= {6'b0, w_spawn_x};
            met_y <= '0;
         end else if (w_move && !w_exit) begin
            met_y <= w_ny[15:0];
         end
         if (r_state == S_HIT && start) dodge_count <= '0;
         else if (w_exit && dodge_count != 16'hFFFF) dodge_count <= dodge_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_meteor_mover.sv
// tb_meteor_mover: randomized scenarios for meteor_mover checked against a frame-level model of the game rules.
module tb_meteor_mover;
   logic        clk = 1'b0, rst = 1'b1, frame = 1'b0, start = 1'b0, pause = 1'b0, collide = 1'b0;
   logic [15:0] speed = '0;
   logic [15:0] met_x, met_y, dodge_count;
   logic        met_active, hit, dodged;
   int          pass_cnt = 0, total_cnt = 0;
   logic [15:0] m_lfsr, e_x, e_y, e_cnt;
   logic        e_hit;

   meteor_mover dut (
      .clk(clk), .rst(rst), .frame(frame), .speed(speed), .start(start), .pause(pause),
      .collide(collide), .met_x(met_x), .met_y(met_y), .met_active(met_active), .hit(hit),
      .dodged(dodged), .dodge_count(dodge_count)
   );

   always #5 clk = ~clk;

   // reference pseudo-random sequence: Galois right shift, mask B400, reseeded by rst
   always @(posedge clk) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input string nm);
      frame = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      e_x = (m_lfsr & 16'h03FF) % 16'd624;
      if (e_hit) e_cnt = '0;
      e_hit = 1'b0;
      e_y = '0;
      total_cnt++; if (hit !== 1'b0) $display("FAIL %s hit: got %0d expected 0", nm, hit); else pass_cnt++;
      total_cnt++; if (dodge_count !== e_cnt) $display("FAIL %s dodge_count: got %0d expected %0d", nm, dodge_count, e_cnt); else pass_cnt++;
      cyc();
      total_cnt++; if (met_x !== e_x) $display("FAIL %s met_x: got %0d expected %0d", nm, met_x, e_x); else pass_cnt++;
      total_cnt++; if (met_y !== e_y) $display("FAIL %s met_y: got %0d expected %0d", nm, met_y, e_y); else pass_cnt++;
      total_cnt++; if (met_active !== 1'b1) $display("FAIL %s met_active: got %0d expected 1", nm, met_active); else pass_cnt++;
   endtask

   task automatic do_tick(input int hi, input string nm);
      int st, ny;
      bit ex;
      frame = 1'b0;
      cyc();
      frame = 1'b1;
      cyc();
      ex = 1'b0;
      if (!e_hit && !pause) begin
         st = int'(speed);
`ifdef METEOR_ACCEL_EN
         st = st + int'(e_cnt >> 4);
         if (st > 65535) st = 65535;
`endif
         ny = int'(e_y) + st;
         if (ny >= 480) begin
            ex = 1'b1;
            e_y = '0;
            if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
            e_x = (m_lfsr & 16'h03FF) % 16'd624;
         end else begin
            e_y = 16'(ny);
         end
      end
      total_cnt++; if (dodged !== ex) $display("FAIL %s dodged: got %0d expected %0d", nm, dodged, ex); else pass_cnt++;
      repeat (hi - 1) cyc();
      frame = 1'b0;
      if (ex && hi == 1) cyc();
      total_cnt++; if (met_y !== e_y) $display("FAIL %s met_y: got %0d expected %0d", nm, met_y, e_y); else pass_cnt++;
      total_cnt++; if (met_x !== e_x) $display("FAIL %s met_x: got %0d expected %0d", nm, met_x, e_x); else pass_cnt++;
      total_cnt++; if (dodge_count !== e_cnt) $display("FAIL %s dodge_count: got %0d expected %0d", nm, dodge_count, e_cnt); else pass_cnt++;
      total_cnt++; if (hit !== e_hit) $display("FAIL %s hit: got %0d expected %0d", nm, hit, e_hit); else pass_cnt++;
      if (ex) begin
         total_cnt++; if (dodged !== 1'b0) $display("FAIL %s dodged_width: got %0d expected 0", nm, dodged); else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      e_x = '0; e_y = '0; e_cnt = '0; e_hit = 1'b0;
      total_cnt++; if (met_x !== 16'd0) $display("FAIL reset met_x: got %0d expected 0", met_x); else pass_cnt++;
      total_cnt++; if (met_y !== 16'd0) $display("FAIL reset met_y: got %0d expected 0", met_y); else pass_cnt++;
      total_cnt++; if (met_active !== 1'b0) $display("FAIL reset met_active: got %0d expected 0", met_active); else pass_cnt++;
      total_cnt++; if (hit !== 1'b0) $display("FAIL reset hit: got %0d expected 0", hit); else pass_cnt++;
      total_cnt++; if (dodged !== 1'b0) $display("FAIL reset dodged: got %0d expected 0", dodged); else pass_cnt++;
      total_cnt++; if (dodge_count !== 16'd0) $display("FAIL reset dodge_count: got %0d expected 0", dodge_count); else pass_cnt++;
      rst = 1'b0;
      collide = 1'b1;
      frame = 1'b1;
      cyc();
      cyc();
      collide = 1'b0;
      frame = 1'b0;
      total_cnt++; if (hit !== 1'b0) $display("FAIL idle_collide hit: got %0d expected 0", hit); else pass_cnt++;
      total_cnt++; if (met_active !== 1'b0) $display("FAIL idle_collide met_active: got %0d expected 0", met_active); else pass_cnt++;
   endtask

   task automatic test_spawn();
      do_start("spawn");
      speed = 16'd4;
      do_tick(2, "long_frame");
      cyc();
      total_cnt++; if (met_y !== 16'd4) $display("FAIL long_frame_once met_y: got %0d expected 4", met_y); else pass_cnt++;
   endtask

   task automatic test_dodge();
      speed = 16'd100;
      for (int i = 0; i < 6 && e_y != 16'd0 || i == 0; i++) do_tick(1, "dodge_drain");
      for (int i = 0; i < 5; i++) do_tick(1, "dodge_run");
      total_cnt++; if (met_y !== 16'd0) $display("FAIL dodge_run_end met_y: got %0d expected 0", met_y); else pass_cnt++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         speed = 16'($urandom_range(0, 520));
         pause = ($urandom_range(0, 3) == 0);
         start = $urandom_range(0, 1) == 1;
         do_tick($urandom_range(1, 3), "random");
         start = 1'b0;
         pause = 1'b0;
      end
   endtask

   task automatic test_collide();
      speed = 16'd480;
      do_tick(1, "collide_prep");
      speed = 16'd40;
      do_tick(1, "collide_to40");
      frame = 1'b0;
      cyc();
      frame = 1'b1;
      collide = 1'b1;
      cyc();
      frame = 1'b0;
      collide = 1'b0;
      e_hit = 1'b1;
      total_cnt++; if (hit !== 1'b1) $display("FAIL collide hit: got %0d expected 1", hit); else pass_cnt++;
      total_cnt++; if (met_y !== e_y) $display("FAIL collide met_y: got %0d expected %0d", met_y, e_y); else pass_cnt++;
      total_cnt++; if (met_active !== 1'b1) $display("FAIL collide met_active: got %0d expected 1", met_active); else pass_cnt++;
      do_tick(1, "hit_frozen");
      do_tick(2, "hit_frozen_long");
      do_start("restart");
   endtask

   task automatic test_pause();
      logic [15:0] y0;
      speed = 16'd8;
      y0 = e_y;
      pause = 1'b1;
      for (int i = 0; i < 3; i++) do_tick(1, "paused");
      pause = 1'b0;
      do_tick(1, "unpaused");
      total_cnt++; if (met_y !== y0 + 16'd8) $display("FAIL unpause_step met_y: got %0d expected %0d", met_y, y0 + 16'd8); else pass_cnt++;
   endtask

   task automatic test_accel();
      logic [15:0] y0, exp_step;
      speed = 16'd480;
      for (int i = 0; i < 64 && e_cnt < 16'd32; i++) do_tick(1, "accel_fill");
      speed = 16'd2;
      y0 = e_y;
`ifdef METEOR_ACCEL_EN
      exp_step = 16'd4;
`else
      exp_step = 16'd2;
`endif
      do_tick(1, "accel_step");
      total_cnt++; if (met_y !== y0 + exp_step) $display("FAIL accel_step32 met_y: got %0d expected %0d", met_y, y0 + exp_step); else pass_cnt++;
      do_tick(1, "accel_step2");
   endtask

   task automatic test_mid_reset();
      speed = 16'd8;
      do_tick(1, "pre_reset");
      rst = 1'b1;
      start = 1'b1;
      collide = 1'b1;
      cyc();
      rst = 1'b0;
      start = 1'b0;
      collide = 1'b0;
      e_x = '0; e_y = '0; e_cnt = '0; e_hit = 1'b0;
      total_cnt++; if (met_active !== 1'b0) $display("FAIL midrst met_active: got %0d expected 0", met_active); else pass_cnt++;
      total_cnt++; if (met_x !== 16'd0) $display("FAIL midrst met_x: got %0d expected 0", met_x); else pass_cnt++;
      total_cnt++; if (met_y !== 16'd0) $display("FAIL midrst met_y: got %0d expected 0", met_y); else pass_cnt++;
      total_cnt++; if (dodge_count !== 16'd0) $display("FAIL midrst dodge_count: got %0d expected 0", dodge_count); else pass_cnt++;
      cyc();
      do_start("post_reset_spawn");
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_dodge();
      test_random();
      test_collide();
      test_pause();
      test_accel();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
